// File: rtl/sopc_2_btn_pkg.sv
// Shared definitions for the SOPC button controller: register addresses,
// event-entry layout and readback bit positions.
package sopc_2_btn_pkg;

    // Avalon-MM word addresses
    localparam logic [1:0] ADDR_LEVELS = 2'd0;
    localparam logic [1:0] ADDR_EVENT  = 2'd1;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // Event entry bit positions
    localparam int EVT_TYPE_BIT = 8;
    localparam int EVT_IDX_MSB  = 7;

    // Readback bit positions
    localparam int RD_VALID_BIT = 31;
    localparam int RD_OVF_BIT   = 30;
    localparam int ST_OVF_BIT   = 8;
    localparam int CNT_W        = 7;

    // Event types
    localparam logic EVT_RELEASE = 1'b0;
    localparam logic EVT_PRESS   = 1'b1;

    typedef struct packed {
        logic       evt_type;   // 1 = press, 0 = release
        logic [7:0] index;      // channel number
    } btn_evt_t;

    // Build the event-port read word from its fields
    function automatic logic [31:0] pack_event(input logic valid, input logic ovf,
                                               input btn_evt_t evt);
        logic [31:0] word;
        word                            = '0;
        word[RD_VALID_BIT]              = valid;
        word[RD_OVF_BIT]                = ovf;
        word[EVT_TYPE_BIT]              = evt.evt_type;
        word[EVT_IDX_MSB:0]             = evt.index;
        return word;
    endfunction

endpackage

// File: rtl/sopc_2_btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and stable level.
// update pulses (combinationally) in the cycle the stable level will flip.
module sopc_2_btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic update
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          synced;
    logic [CW-1:0] cnt_q;

    assign synced = sync_q[1];
    assign update = (synced != stable) && (cnt_q == CNT_MAX);

    // Bring the asynchronous button level into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let both flops sample the pre-edge values, forming a true 2-stage shift.
            sync_q <= {sync_q[0], raw};
        end
    end

    // Count cycles of disagreement; accept the new level once it has held long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            stable <= 1'b0;
        end else if (synced == stable) begin
            cnt_q <= '0;
        end else if (update) begin
            cnt_q  <= '0;
            stable <= synced;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/sopc_2_button_ctrl.sv
// Debounced button controller with an event FIFO and Avalon-MM register file.
// Optional feature: define BTN_RELEASE_EVT_EN to also queue release events.
module sopc_2_button_ctrl
    import sopc_2_btn_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] upd;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] set_mask;
    logic [N_BTN-1:0] clr_mask;
    logic [N_BTN-1:0] pending;

    logic             push_req;
    btn_evt_t         push_evt;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             ovf_clr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             rd_en;
    logic             wr_en;

    btn_evt_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             irq_en;
    logic [31:0]      rd_word;

    // One debouncer per button channel
    for (genvar g = 0; g < N_BTN; g++) begin : g_deb
        sopc_2_btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (in_port[g]),
            .stable  (stable[g]),
            .update  (upd[g])
        );
    end

    assign rise = upd & ~stable;

`ifdef BTN_RELEASE_EVT_EN
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] pend_type;

    assign fall     = upd & stable;
    assign set_mask = rise | fall;

    // Remember whether each pending event is a press or a release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_type <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (set_mask[i]) pend_type[i] <= rise[i];
            end
        end
    end
`else
    assign set_mask = rise;
`endif

    // Select the lowest-index pending channel for this cycle's push
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        push_req = 1'b0;
        push_evt = '{evt_type: EVT_PRESS, index: 8'd0};
        clr_mask = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (pending[i] && !push_req) begin
                push_req       = 1'b1;
                push_evt.index = 8'(i);
`ifdef BTN_RELEASE_EVT_EN
                push_evt.evt_type = pend_type[i] ? EVT_PRESS : EVT_RELEASE;
`endif
                clr_mask[i]    = 1'b1;
            end
        end
    end

    assign rd_en      = chipselect & ~read_n;
    assign wr_en      = chipselect & ~write_n;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign pop        = rd_en && (address == ADDR_EVENT) && !fifo_empty;
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign ovf_clr    = wr_en && (address == ADDR_STATUS) && writedata[ST_OVF_BIT];
    assign irq        = irq_en & ~fifo_empty;

    // Pending bits: serviced one per cycle, new stable transitions win over a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // Event storage
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; pointers and count alone decide what is valid.
        if (push) mem[wr_ptr] <= push_evt;
    end

    // FIFO pointers, count, sticky overflow and the irq enable register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            overflow <= ovf_set | (overflow & ~ovf_clr);
            if (wr_en && (address == ADDR_IRQ_EN)) irq_en <= writedata[0];
        end
    end

    // Read multiplexer
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_LEVELS: rd_word = 32'(stable);
            ADDR_EVENT: begin
                if (fifo_empty) begin
                    rd_word[RD_OVF_BIT] = overflow;
                end else begin
                    rd_word = pack_event(1'b1, overflow, mem[rd_ptr]);
                end
            end
            ADDR_IRQ_EN: rd_word[0] = irq_en;
            default: begin
                rd_word[CNT_W-1:0]  = count;
                rd_word[ST_OVF_BIT] = overflow;
            end
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_word;
        end
    end

    // Write-data bits with no register behind them
    logic unused_wdata;
    assign unused_wdata = ^{writedata[31:9], writedata[7:1]};

endmodule

// File: tb/tb_sopc_2_button_ctrl.sv
// Self-checking bench for sopc_2_button_ctrl (DEB_CYCLES=4, FIFO_DEPTH=4).
// Build with BTN_RELEASE_EVT_EN defined to exercise release events as well.
module tb_sopc_2_button_ctrl;

    localparam int N_BTN  = 4;
    localparam int DEB    = 4;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 14;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N_BTN-1:0] in_port;
    logic [1:0]       address;
    logic             chipselect;
    logic             read_n;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic             irq;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: expected {type, index} entries in queue order
    logic [8:0]       sb_q[$];
    logic             mdl_ovf;
    logic             mdl_irq_en;
    logic [N_BTN-1:0] mdl_btn;

    sopc_2_button_ctrl #(
        .N_BTN      (N_BTN),
        .DEB_CYCLES (DEB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        d          = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = data;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic model_event(input logic t, input int i);
        if (sb_q.size() == DEPTH) mdl_ovf = 1'b1;
        else                      sb_q.push_back({t, 8'(i)});
    endtask

    // Drive new button levels and record the events they should produce
    task automatic apply_buttons(input logic [N_BTN-1:0] v);
        in_port = v;
        for (int i = 0; i < N_BTN; i++) begin
            if (v[i] && !mdl_btn[i]) model_event(1'b1, i);
`ifdef BTN_RELEASE_EVT_EN
            else if (!v[i] && mdl_btn[i]) model_event(1'b0, i);
`endif
        end
        mdl_btn = v;
    endtask

    task automatic set_buttons(input logic [N_BTN-1:0] v);
        apply_buttons(v);
        tick(SETTLE);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_read(2'd3, d);
        check(tag, d, {23'b0, mdl_ovf, 1'b0, 7'(sb_q.size())});
    endtask

    task automatic check_irq(input string tag);
        check(tag, 32'(irq), 32'(mdl_irq_en && (sb_q.size() != 0)));
    endtask

    // Pop up to n entries, comparing each against the scoreboard front
    task automatic drain_n(input string tag, input int n);
        logic [31:0] d;
        logic [8:0]  e;
        for (int k = 0; k < n && sb_q.size() > 0; k++) begin
            e = sb_q.pop_front();
            bus_read(2'd1, d);
            check(tag, d, {1'b1, mdl_ovf, 21'b0, e});
        end
    endtask

    task automatic drain(input string tag);
        drain_n(tag, DEPTH);
        check_status({tag, "_status"});
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        sb_q.delete();
        mdl_ovf    = 1'b0;
        mdl_irq_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] d;
        int          prev_cnt;
        int          cur_cnt;

        reset_n    = 1'b0;
        in_port    = '0;
        address    = '0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        mdl_ovf    = 1'b0;
        mdl_irq_en = 1'b0;
        mdl_btn    = '0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Reset state
        check("rst_readdata", readdata, 32'h0);
        check_irq("rst_irq");
        bus_read(2'd0, d);
        check("rst_levels", d, 32'h0);
        check_status("rst_status");
        bus_read(2'd2, d);
        check("rst_irq_en", d, 32'h0);

        bus_write(2'd2, 32'h1);
        mdl_irq_en = 1'b1;
        bus_read(2'd2, d);
        check("irq_en_rb", d, 32'h1);

        // Single press on channel 2
        set_buttons(4'b0100);
        check_irq("press2_irq");
        check_status("press2_status");
        bus_read(2'd0, d);
        check("press2_levels", d, 32'h4);
        void'(sb_q.pop_front());
        bus_read(2'd1, d);
        check("press2_event", d, 32'h8000_0102);
        check_irq("press2_irq_after_pop");
        check_status("press2_status_after_pop");
        set_buttons(4'b0000);
        drain("rel2");

        // Short glitch is rejected
        in_port = 4'b0001;
        tick(3);
        in_port = 4'b0000;
        tick(SETTLE);
        bus_read(2'd0, d);
        check("glitch_levels", d, 32'h0);
        check_status("glitch_status");

        // All four together: count rises by at most one per cycle
        apply_buttons(4'b1111);
        prev_cnt = 0;
        for (int c = 0; c < SETTLE; c++) begin
            bus_read(2'd3, d);
            cur_cnt = int'(d[6:0]);
            check("one_push_per_cycle", 32'(cur_cnt - prev_cnt > 1), 32'h0);
            prev_cnt = cur_cnt;
        end
        check_status("all4_status");
        bus_read(2'd0, d);
        check("all4_levels", d, 32'hF);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        check_status("ro_write_status");
        bus_read(2'd0, d);
        check("ro_write_levels", d, 32'hF);
        drain("all4_order");
        set_buttons(4'b0000);
        drain("all4_release");

        // Overflow: six presses without popping
        set_buttons(4'b1111);
        set_buttons(4'b0000);
        set_buttons(4'b0011);
        check("ovf_model", 32'(mdl_ovf), 32'h1);
        check_status("ovf_status");
        check_irq("ovf_irq");
        drain_n("ovf_first_pop", 1);
        bus_write(2'd3, 32'h0000_0100);
        mdl_ovf = 1'b0;
        check_status("ovf_cleared");
        drain("ovf_retained");
        set_buttons(4'b0000);
        drain("ovf_release");

        // Empty read, then reset with queued entries
        bus_read(2'd1, d);
        check("empty_read", d, 32'h0);
        check_status("empty_status");
        set_buttons(4'b0011);
        set_buttons(4'b0000);
        check_irq("queued_irq");
        check_status("queued_status");
        pulse_reset();
        check_irq("post_rst_irq");
        check_status("post_rst_status");
        bus_read(2'd2, d);
        check("post_rst_irq_en", d, 32'h0);
        tick(SETTLE);
        check_status("post_rst_quiet");

        // Press then release channel 1
        bus_write(2'd2, 32'h1);
        mdl_irq_en = 1'b1;
        set_buttons(4'b0010);
        set_buttons(4'b0000);
        check_irq("pr1_irq");
        drain("pr1_events");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sopc_2_button_ctrl.md
SOPC_2_BUTTON_CTRL -- requirements
Module: sopc_2_button_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of button inputs (1..8).
REQ-002 Parameter DEB_CYCLES, default 50000: clk cycles an input must hold a new level before it is accepted.
REQ-003 Parameter FIFO_DEPTH, default 8: event queue entries (power of two, 2..64).
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_port  input  N_BTN  raw button levels, asynchronous to clk, 1 = pressed.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 read_n  input  1  active-low read strobe.
REQ-010 write_n  input  1  active-low write strobe.
REQ-011 writedata  input  32  write data.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 Each in_port bit SHALL pass a 2-flop synchronizer before any other use.
REQ-015 Per channel: counter clears while synced level equals stable level; otherwise increments; on reaching DEB_CYCLES-1 the stable level takes the synced level and the counter clears.
REQ-016 A stable 0->1 transition SHALL set that channel's pending bit in the same cycle the stable level updates.
REQ-017 Each cycle the lowest-index pending channel SHALL be pushed into the FIFO and its pending bit cleared; one push per cycle maximum.
REQ-018 FIFO entry = {type[8], index[7:0]}; type 1 = press, 0 = release.
REQ-019 Push while full SHALL drop the event, clear its pending bit, and set sticky overflow.
REQ-020 Simultaneous push and pop when full SHALL both occur; overflow is not set.
REQ-021 Register map (readdata valid the cycle after chipselect & ~read_n, else previous value held):
- addr 0 RO: stable levels in bits [N_BTN-1:0], zero-extended.
- addr 1 RO+pop: bit31 valid, bit30 overflow, bit8 type, bits[7:0] index; read pops only when non-empty; empty read returns valid=0, pointers unchanged.
- addr 2 RW: bit0 irq enable.
- addr 3 status: bits[6:0] FIFO count, bit8 overflow; writing 1 to bit8 clears overflow.
REQ-022 Write to overflow-clear coinciding with a new overflow SHALL leave overflow set.
REQ-023 irq SHALL equal irq_enable & (count != 0), combinational from registers.
REQ-024 Writes to addr 0/1 SHALL have no effect.

Reset
REQ-025 reset_n low SHALL clear synchronizers, counters, stable levels, pending, FIFO pointers and count, overflow, irq_enable, readdata; irq = 0.
REQ-026 Reset asserted mid-debounce or with queued events SHALL discard them; no event is generated by the first post-reset stable update from 0 unless it is a 0->1 transition after DEB_CYCLES.

Configuration
REQ-027 Macro BTN_RELEASE_EVT_EN defined: stable 1->0 transitions SHALL also set pending and queue type=0 entries.
REQ-028 Macro undefined: only press events exist; type bit reads 1 always; release logic absent.

Structure
REQ-029 Shared package sopc_2_btn_pkg SHALL hold register address constants, event-entry bit positions, and the event entry typedef.
REQ-030 Sub-module sopc_2_btn_debounce (synchronizer + counter + stable level, one channel) SHALL be instantiated N_BTN times; FIFO and register file stay in the top.

Verification (bench uses DEB_CYCLES=4, FIFO_DEPTH=4)
REQ-031 in_port[2] 0->1 held 10 cycles, irq_enable=1 -> one entry {valid,type=1,index=2}; irq high until addr1 read; count 1->0.
REQ-032 in_port[0] glitch high for 3 cycles -> no event, addr0 reads 0.
REQ-033 in_port[3:0] 0000->1111 together -> entries popped in order 0,1,2,3; one push per cycle.
REQ-034 Six press events without pops -> count 4, overflow=1, first four indices retained; write 0x100 to addr3 -> overflow=0.
REQ-035 Read addr1 when empty -> readdata 0x00000000, count stays 0; reset_n pulsed with 2 queued entries -> count 0, irq 0.
REQ-036 With BTN_RELEASE_EVT_EN, press then release in_port[1] -> entries type=1 then type=0, index=1.
